// File: rtl/pipeline_mem_arbiter_if.sv
// Pipeline-to-memory bundle: I-port, D-port, memory port and current owner.
// master = pipeline/memory side, slave = the arbiter.
interface pipeline_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_ready;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ready;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic [1:0]        owner;

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_rdata, i_ready, d_rdata, d_ready,
    input  mem_en, mem_we, mem_addr, mem_wdata, owner
  );

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_rdata, i_ready, d_rdata, d_ready,
    output mem_en, mem_we, mem_addr, mem_wdata, owner
  );
endinterface

// File: rtl/pipeline_mem_arbiter.sv
// Shares one fixed-latency memory between fetch (I) and memory stage (D); D wins unless I is starved.
// Latency: request seen in IDLE at t -> mem_en at t+1, ready at t+MEM_LAT+2; requesters stall until their ready pulse.
module pipeline_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  pipeline_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_I    = 2'b01;
  localparam logic [1:0] OWN_D    = 2'b10;
  localparam logic [3:0] LAT_INIT = 4'(MEM_LAT - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t            state_q;
  logic [3:0]        lat_q;
  logic [3:0]        starve_q, starve_d;
  logic              mem_en_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] i_rdata_q, d_rdata_q;
  logic              i_ready_q, d_ready_q;
  logic [1:0]        owner_q;

  logic starved, grant_i, grant_d;

  always_comb begin
    starved = bus.i_req && (starve_q == STARVE_LIM);
    grant_d = (state_q == IDLE) && bus.d_req && !starved;
    grant_i = (state_q == IDLE) && bus.i_req && (starved || !bus.d_req);

    starve_d = starve_q;
    if (grant_i) begin
      starve_d = '0;
    end else if (grant_d && bus.i_req && (starve_q != STARVE_LIM)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      lat_q       <= '0;
      starve_q    <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_ready_q   <= 1'b0;
      d_ready_q   <= 1'b0;
      owner_q     <= OWN_NONE;
    end else begin
      starve_q <= starve_d;
      case (state_q)
        IDLE: begin
          if (grant_d) begin
            mem_addr_q  <= bus.d_addr;
            mem_we_q    <= bus.d_we;
            mem_wdata_q <= bus.d_wdata;
            mem_en_q    <= 1'b1;
            owner_q     <= OWN_D;
            state_q     <= ACCESS;
          end else if (grant_i) begin
            mem_addr_q  <= bus.i_addr;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            mem_en_q    <= 1'b1;
            owner_q     <= OWN_I;
            state_q     <= ACCESS;
          end
        end
        ACCESS: begin
          mem_en_q <= 1'b0;
          lat_q    <= LAT_INIT;
          state_q  <= WAIT;
        end
        WAIT: begin
          // Counter hits zero in exactly the cycle the memory drives valid data.
          if (lat_q == 4'd0) begin
            if (owner_q == OWN_D) begin
              d_rdata_q <= bus.mem_rdata;
              d_ready_q <= 1'b1;
            end else begin
              i_rdata_q <= bus.mem_rdata;
              i_ready_q <= 1'b1;
            end
            state_q <= DONE;
          end else begin
            lat_q <= lat_q - 4'd1;
          end
        end
        DONE: begin
          i_ready_q <= 1'b0;
          d_ready_q <= 1'b0;
          owner_q   <= OWN_NONE;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.i_ready   = i_ready_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.d_ready   = d_ready_q;
  assign bus.owner     = owner_q;

endmodule

// File: tb/tb_pipeline_mem_arbiter.sv
// Directed bench for pipeline_mem_arbiter with MEM_LAT=2, STARVE_MAX=3 and a read-only memory model.
module tb_pipeline_mem_arbiter;

  localparam int LAT = 2;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   errors  = 0;

  always #5 clk = ~clk;

  pipeline_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  pipeline_mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .STARVE_MAX(3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Memory returns data only in the cycle exactly LAT cycles after mem_en.
  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a == 32'h64) ? 32'h7 : (32'hC0DE_0000 | a);
  endfunction

  logic        v_q [LAT] = '{default: 1'b0};
  logic [31:0] r_q [LAT] = '{default: 32'h0};

  always @(posedge clk) begin
    v_q[0] <= bus.mem_en;
    r_q[0] <= rom(bus.mem_addr);
    for (int k = 1; k < LAT; k++) begin
      v_q[k] <= v_q[k-1];
      r_q[k] <= r_q[k-1];
    end
  end

  assign bus.mem_rdata = v_q[LAT-1] ? r_q[LAT-1] : 32'hBAD0_BAD0;

  task automatic test_reset;
    reset = 1'b0;
    bus.i_req = 0; bus.i_addr = 0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0;
    repeat (2) @(negedge clk);
    vectors++; if (bus.mem_en !== 1'b0) begin errors++; $display("FAIL rst_mem_en got %0b exp 0", bus.mem_en); end
    vectors++; if (bus.owner !== 2'b00) begin errors++; $display("FAIL rst_owner got %b exp 00", bus.owner); end
    vectors++; if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL rst_mem_addr got %h exp 0", bus.mem_addr); end
    vectors++; if ({bus.i_ready, bus.d_ready} !== 2'b00) begin errors++; $display("FAIL rst_ready got %b exp 00", {bus.i_ready, bus.d_ready}); end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    vectors++; if (bus.mem_en !== 1'b0) begin errors++; $display("FAIL idle_mem_en got %0b exp 0", bus.mem_en); end
  endtask

  task automatic test_single_load;
    @(posedge clk); #1;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h64;
    @(negedge clk); // t
    vectors++; if (bus.mem_en !== 1'b0) begin errors++; $display("FAIL load_t0_mem_en got %0b exp 0", bus.mem_en); end
    @(negedge clk); // t+1
    vectors++; if (bus.mem_en !== 1'b1) begin errors++; $display("FAIL load_mem_en got %0b exp 1", bus.mem_en); end
    vectors++; if (bus.mem_addr !== 32'h64) begin errors++; $display("FAIL load_mem_addr got %h exp 64", bus.mem_addr); end
    vectors++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL load_mem_we got %0b exp 0", bus.mem_we); end
    vectors++; if (bus.owner !== 2'b10) begin errors++; $display("FAIL load_owner got %b exp 10", bus.owner); end
    @(negedge clk); // t+2
    vectors++; if (bus.mem_en !== 1'b0) begin errors++; $display("FAIL load_mem_en_once got %0b exp 0", bus.mem_en); end
    @(negedge clk); // t+3
    vectors++; if (bus.d_ready !== 1'b0) begin errors++; $display("FAIL load_early_ready got %0b exp 0", bus.d_ready); end
    @(negedge clk); // t+4
    vectors++; if (bus.d_ready !== 1'b1) begin errors++; $display("FAIL load_d_ready got %0b exp 1", bus.d_ready); end
    vectors++; if (bus.d_rdata !== 32'h7) begin errors++; $display("FAIL load_d_rdata got %h exp 7", bus.d_rdata); end
    bus.d_req = 0;
    @(negedge clk); // t+5
    vectors++; if (bus.d_ready !== 1'b0) begin errors++; $display("FAIL load_ready_pulse got %0b exp 0", bus.d_ready); end
    vectors++; if (bus.owner !== 2'b00) begin errors++; $display("FAIL load_owner_idle got %b exp 00", bus.owner); end
  endtask

  task automatic test_single_store;
    @(posedge clk); #1;
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h64; bus.d_wdata = 32'h7;
    repeat (2) @(negedge clk); // t+1
    vectors++; if (bus.mem_en !== 1'b1) begin errors++; $display("FAIL store_mem_en got %0b exp 1", bus.mem_en); end
    vectors++; if (bus.mem_we !== 1'b1) begin errors++; $display("FAIL store_mem_we got %0b exp 1", bus.mem_we); end
    vectors++; if (bus.mem_addr !== 32'h64) begin errors++; $display("FAIL store_mem_addr got %h exp 64", bus.mem_addr); end
    vectors++; if (bus.mem_wdata !== 32'h7) begin errors++; $display("FAIL store_mem_wdata got %h exp 7", bus.mem_wdata); end
    @(negedge clk); // t+2
    vectors++; if (bus.mem_en !== 1'b0) begin errors++; $display("FAIL store_mem_en_once got %0b exp 0", bus.mem_en); end
    repeat (2) @(negedge clk); // t+4
    vectors++; if (bus.d_ready !== 1'b1) begin errors++; $display("FAIL store_d_ready got %0b exp 1", bus.d_ready); end
    vectors++; if (bus.i_ready !== 1'b0) begin errors++; $display("FAIL store_i_ready got %0b exp 0", bus.i_ready); end
    bus.d_req = 0; bus.d_we = 0; bus.d_wdata = 0;
    @(negedge clk);
  endtask

  task automatic test_simultaneous;
    @(posedge clk); #1;
    bus.i_req = 1; bus.i_addr = 32'h0;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h60;
    repeat (2) @(negedge clk); // t+1
    vectors++; if (bus.owner !== 2'b10) begin errors++; $display("FAIL sim_first_owner got %b exp 10", bus.owner); end
    vectors++; if (bus.mem_addr !== 32'h60) begin errors++; $display("FAIL sim_first_addr got %h exp 60", bus.mem_addr); end
    repeat (3) @(negedge clk); // t+4
    vectors++; if (bus.d_ready !== 1'b1) begin errors++; $display("FAIL sim_d_ready got %0b exp 1", bus.d_ready); end
    vectors++; if (bus.d_rdata !== 32'hC0DE_0060) begin errors++; $display("FAIL sim_d_rdata got %h exp c0de0060", bus.d_rdata); end
    vectors++; if (bus.i_ready !== 1'b0) begin errors++; $display("FAIL sim_i_ready_early got %0b exp 0", bus.i_ready); end
    // Non-owner D inputs change while I is served; none may reach memory.
    bus.d_req = 0; bus.d_we = 1; bus.d_addr = 32'hFFC; bus.d_wdata = 32'hFFFF;
    @(negedge clk); // t+5
    vectors++; if (bus.owner !== 2'b00) begin errors++; $display("FAIL sim_idle_owner got %b exp 00", bus.owner); end
    @(negedge clk); // t+6
    vectors++; if (bus.owner !== 2'b01) begin errors++; $display("FAIL sim_second_owner got %b exp 01", bus.owner); end
    vectors++; if (bus.mem_en !== 1'b1) begin errors++; $display("FAIL sim_i_mem_en got %0b exp 1", bus.mem_en); end
    vectors++; if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL sim_i_addr got %h exp 0", bus.mem_addr); end
    vectors++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL sim_i_we got %0b exp 0", bus.mem_we); end
    repeat (3) @(negedge clk); // t+9
    vectors++; if (bus.i_ready !== 1'b1) begin errors++; $display("FAIL sim_i_ready got %0b exp 1", bus.i_ready); end
    vectors++; if (bus.i_rdata !== 32'hC0DE_0000) begin errors++; $display("FAIL sim_i_rdata got %h exp c0de0000", bus.i_rdata); end
    bus.i_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0;
    @(negedge clk);
  endtask

  task automatic test_starvation;
    logic [1:0] exp_own [8];
    exp_own = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b10, 2'b01};
    @(posedge clk); #1;
    bus.i_req = 1; bus.i_addr = 32'h100;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h200;
    for (int k = 0; k < 8; k++) begin
      repeat ((k == 0) ? 2 : 5) @(negedge clk); // ACCESS cycle of grant k
      vectors++;
      if (bus.owner !== exp_own[k]) begin
        errors++; $display("FAIL starve_grant%0d got %b exp %b", k, bus.owner, exp_own[k]);
      end
    end
    bus.i_req = 0; bus.d_req = 0;
    repeat (3) @(negedge clk);
    vectors++; if (bus.i_ready !== 1'b1) begin errors++; $display("FAIL starve_last_i_ready got %0b exp 1", bus.i_ready); end
    vectors++; if (bus.i_rdata !== 32'hC0DE_0100) begin errors++; $display("FAIL starve_i_rdata got %h exp c0de0100", bus.i_rdata); end
    repeat (2) @(negedge clk);
    vectors++; if (bus.owner !== 2'b00) begin errors++; $display("FAIL starve_end_owner got %b exp 00", bus.owner); end
  endtask

  task automatic test_dropped_req;
    @(posedge clk); #1;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h80;
    repeat (2) @(negedge clk); // t+1, ACCESS
    bus.d_req = 0;
    repeat (3) @(negedge clk); // t+4
    vectors++; if (bus.d_ready !== 1'b1) begin errors++; $display("FAIL drop_d_ready got %0b exp 1", bus.d_ready); end
    vectors++; if (bus.d_rdata !== 32'hC0DE_0080) begin errors++; $display("FAIL drop_d_rdata got %h exp c0de0080", bus.d_rdata); end
    @(negedge clk); // t+5
    vectors++; if (bus.d_ready !== 1'b0) begin errors++; $display("FAIL drop_ready_once got %0b exp 0", bus.d_ready); end
    @(negedge clk); // t+6
    vectors++; if (bus.mem_en !== 1'b0) begin errors++; $display("FAIL drop_regrant got %0b exp 0", bus.mem_en); end
    vectors++; if (bus.owner !== 2'b00) begin errors++; $display("FAIL drop_owner got %b exp 00", bus.owner); end
  endtask

  task automatic test_reset_mid;
    @(posedge clk); #1;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h68;
    repeat (4) @(negedge clk); // t+3, WAIT
    reset = 1'b0;
    #1;
    vectors++; if (bus.owner !== 2'b00) begin errors++; $display("FAIL rmid_owner got %b exp 00", bus.owner); end
    vectors++; if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL rmid_mem_addr got %h exp 0", bus.mem_addr); end
    vectors++; if (bus.d_rdata !== 32'h0) begin errors++; $display("FAIL rmid_d_rdata got %h exp 0", bus.d_rdata); end
    bus.d_req = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      vectors++;
      if (bus.d_ready !== 1'b0) begin errors++; $display("FAIL rmid_no_ready%0d got %0b exp 0", k, bus.d_ready); end
    end
    @(posedge clk); #1;
    bus.i_req = 1; bus.i_addr = 32'h40;
    repeat (2) @(negedge clk); // t+1
    vectors++; if (bus.owner !== 2'b01) begin errors++; $display("FAIL rmid_i_owner got %b exp 01", bus.owner); end
    vectors++; if (bus.mem_en !== 1'b1) begin errors++; $display("FAIL rmid_i_mem_en got %0b exp 1", bus.mem_en); end
    repeat (3) @(negedge clk); // t+4
    vectors++; if (bus.i_ready !== 1'b1) begin errors++; $display("FAIL rmid_i_ready got %0b exp 1", bus.i_ready); end
    vectors++; if (bus.i_rdata !== 32'hC0DE_0040) begin errors++; $display("FAIL rmid_i_rdata got %h exp c0de0040", bus.i_rdata); end
    bus.i_req = 0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_single_store();
    test_simultaneous();
    test_starvation();
    test_dropped_req();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
